// File: rtl/pose_round_ctrl.sv
// pose_round_ctrl: round sequencer for a pose-matching game.
// Shows a target pattern for SHOW_FRAMES frames, judges one frame by counting
// person pixels inside/outside the pattern, holds a verdict for RESULT_FRAMES
// frames, and repeats for NUM_ROUNDS rounds.
// Optional feature: define ROUND_SCORE_ACCUM_EN to add the 7-bit total_score
// output, which accumulates 3/2/0 points per perfect/good/bad round.
module pose_round_ctrl #(
    parameter int SHOW_FRAMES   = 180,
    parameter int RESULT_FRAMES = 120,
    parameter int NUM_ROUNDS    = 5
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       vsync_pulse,
    input  logic       pixel_valid,
    input  logic       in_polygon,
    input  logic       chroma,
    output logic       game_in,
    output logic       judging,
    output logic       perfect,
    output logic       good,
    output logic       bad,
    output logic       result_valid,
    output logic [3:0] round_num,
    output logic       game_over
`ifdef ROUND_SCORE_ACCUM_EN
    ,
    output logic [6:0] total_score
`endif
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        SHOW   = 3'd1,
        JUDGE  = 3'd2,
        RESULT = 3'd3,
        DONE   = 3'd4
    } state_t;

    localparam logic [7:0]  SHOW_LAST   = 8'(SHOW_FRAMES);
    localparam logic [7:0]  RESULT_LAST = 8'(RESULT_FRAMES);
    localparam logic [3:0]  LAST_ROUND  = 4'(NUM_ROUNDS);
    localparam logic [18:0] CNT_MAX     = 19'h7FFFF;

    state_t      state_reg, state_next;
    logic [7:0]  frame_cnt_reg, frame_cnt_next;
    logic [18:0] grn_cnt_reg, grn_cnt_next;
    logic [18:0] red_cnt_reg, red_cnt_next;
    logic [3:0]  round_reg, round_next;
    // Verdict bits ordered {perfect, good, bad}
    logic [2:0]  verdict_reg, verdict_next;

    logic [7:0]  frame_inc;
    logic [19:0] total;
    logic [22:0] grn_x5, total_x4, grn_x2, total_w;
    logic [2:0]  verdict_calc;
    logic        count_pixel;

`ifdef ROUND_SCORE_ACCUM_EN
    logic [6:0]  score_reg, score_next;
    logic [7:0]  score_sum;
    logic [6:0]  score_pts;
`endif

    assign frame_inc   = frame_cnt_reg + 8'd1;
    // A pixel strobe coinciding with vsync belongs to no frame and is dropped
    assign count_pixel = pixel_valid && !chroma && !vsync_pulse;

    // Ratio tests by cross-multiplication: 5*g >= 4*t is g/t >= 80 %, 2*g >= t is >= 50 %
    always_comb begin
        total        = {1'b0, grn_cnt_reg} + {1'b0, red_cnt_reg};
        grn_x5       = 23'(grn_cnt_reg) * 23'd5;
        total_x4     = 23'({total, 2'b00});
        grn_x2       = 23'({grn_cnt_reg, 1'b0});
        total_w      = 23'(total);
        verdict_calc = 3'b001;
        if (total != 20'd0) begin
            if (grn_x5 >= total_x4)
                verdict_calc = 3'b100;
            else if (grn_x2 >= total_w)
                verdict_calc = 3'b010;
        end
    end

`ifdef ROUND_SCORE_ACCUM_EN
    // Points for the verdict being latched, added with saturation at 127
    always_comb begin
        score_pts = 7'd0;
        if (verdict_calc[2])
            score_pts = 7'd3;
        else if (verdict_calc[1])
            score_pts = 7'd2;
        score_sum = {1'b0, score_reg} + {1'b0, score_pts};
    end
`endif

    // Next-state and datapath update; Moore outputs decoded from the current state
    always_comb begin
        state_next     = state_reg;
        frame_cnt_next = frame_cnt_reg;
        grn_cnt_next   = grn_cnt_reg;
        red_cnt_next   = red_cnt_reg;
        round_next     = round_reg;
        verdict_next   = verdict_reg;
`ifdef ROUND_SCORE_ACCUM_EN
        score_next     = score_reg;
`endif
        game_in        = 1'b1;
        judging        = 1'b0;
        result_valid   = 1'b0;
        game_over      = 1'b0;

        unique case (state_reg)
            IDLE, DONE: begin
                game_over = (state_reg == DONE);
                if (start) begin
                    state_next     = SHOW;
                    round_next     = 4'd1;
                    frame_cnt_next = 8'd0;
`ifdef ROUND_SCORE_ACCUM_EN
                    score_next     = 7'd0;
`endif
                end
            end
            SHOW: begin
                if (vsync_pulse) begin
                    if (frame_inc == SHOW_LAST) begin
                        state_next     = JUDGE;
                        frame_cnt_next = 8'd0;
                        grn_cnt_next   = 19'd0;
                        red_cnt_next   = 19'd0;
                    end else begin
                        frame_cnt_next = frame_inc;
                    end
                end
            end
            JUDGE: begin
                game_in = 1'b0;
                judging = 1'b1;
                if (vsync_pulse) begin
                    state_next     = RESULT;
                    verdict_next   = verdict_calc;
                    frame_cnt_next = 8'd0;
`ifdef ROUND_SCORE_ACCUM_EN
                    score_next     = score_sum[7] ? 7'd127 : score_sum[6:0];
`endif
                end else if (count_pixel) begin
                    if (in_polygon) begin
                        if (grn_cnt_reg != CNT_MAX)
                            grn_cnt_next = grn_cnt_reg + 19'd1;
                    end else begin
                        if (red_cnt_reg != CNT_MAX)
                            red_cnt_next = red_cnt_reg + 19'd1;
                    end
                end
            end
            RESULT: begin
                game_in      = 1'b0;
                result_valid = 1'b1;
                if (vsync_pulse) begin
                    if (frame_inc == RESULT_LAST) begin
                        frame_cnt_next = 8'd0;
                        verdict_next   = 3'b000;
                        if (round_reg == LAST_ROUND) begin
                            state_next = DONE;
                        end else begin
                            state_next = SHOW;
                            round_next = round_reg + 4'd1;
                        end
                    end else begin
                        frame_cnt_next = frame_inc;
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    // Counters, round number and verdict registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            frame_cnt_reg <= 8'd0;
            grn_cnt_reg   <= 19'd0;
            red_cnt_reg   <= 19'd0;
            round_reg     <= 4'd0;
            verdict_reg   <= 3'b000;
        end else begin
            frame_cnt_reg <= frame_cnt_next;
            grn_cnt_reg   <= grn_cnt_next;
            red_cnt_reg   <= red_cnt_next;
            round_reg     <= round_next;
            verdict_reg   <= verdict_next;
        end
    end

`ifdef ROUND_SCORE_ACCUM_EN
    // Running game score
    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            score_reg <= 7'd0;
        else
            score_reg <= score_next;
    end

    assign total_score = score_reg;
`endif

    assign round_num = round_reg;
    assign perfect   = verdict_reg[2];
    assign good      = verdict_reg[1];
    assign bad       = verdict_reg[0];

endmodule

// File: tb/tb_pose_round_ctrl.sv
// tb_pose_round_ctrl: table vectors plus random rounds against a ratio-based
// reference model; includes reset-during-judge and start-ignored sequences.
module tb_pose_round_ctrl;

    localparam int NR = 3;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       vsync_pulse = 1'b0;
    logic       pixel_valid = 1'b0;
    logic       in_polygon = 1'b0;
    logic       chroma = 1'b0;
    logic       game_in, judging, perfect, good, bad, result_valid, game_over;
    logic [3:0] round_num;
`ifdef ROUND_SCORE_ACCUM_EN
    logic [6:0] total_score;
`endif

    pose_round_ctrl #(
        .SHOW_FRAMES  (2),
        .RESULT_FRAMES(1),
        .NUM_ROUNDS   (NR)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .vsync_pulse (vsync_pulse),
        .pixel_valid (pixel_valid),
        .in_polygon  (in_polygon),
        .chroma      (chroma),
        .game_in     (game_in),
        .judging     (judging),
        .perfect     (perfect),
        .good        (good),
        .bad         (bad),
        .result_valid(result_valid),
        .round_num   (round_num),
        .game_over   (game_over)
`ifdef ROUND_SCORE_ACCUM_EN
        ,
        .total_score (total_score)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        int         grn;
        int         red;
        int         bg;
        int         vsync_px;
        logic [2:0] exp;
    } vec_t;

    vec_t tbl[7];
    int   compared = 0;
    int   mismatched = 0;

    // Game model
    int   cur_round = 0;
    bit   game_done = 0;
    int   exp_score = 0;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input int actual, input int expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Verdict from percentage rules: >=80 % perfect, >=50 % good, else bad
    function automatic logic [2:0] ref_verdict(input int g, input int r);
        int t;
        t = g + r;
        if (t > 0 && g * 100 >= t * 80) return 3'b100;
        if (t > 0 && g * 100 >= t * 50) return 3'b010;
        return 3'b001;
    endfunction

    function automatic int pts(input logic [2:0] v);
        if (v == 3'b100) return 3;
        if (v == 3'b010) return 2;
        return 0;
    endfunction

    task automatic vsync();
        vsync_pulse = 1'b1;
        tick();
        vsync_pulse = 1'b0;
    endtask

    task automatic send_pixels(input int g, input int r, input int b);
        int rg, rr, rb, pick;
        rg = g; rr = r; rb = b;
        while (rg + rr + rb > 0) begin
            if ($urandom_range(0, 3) == 0) begin
                pixel_valid = 1'b0;
                chroma      = 1'b0;
                in_polygon  = 1'($urandom_range(0, 1));
            end else begin
                pixel_valid = 1'b1;
                pick = $urandom_range(0, rg + rr + rb - 1);
                if (pick < rg) begin
                    chroma = 1'b0; in_polygon = 1'b1; rg--;
                end else if (pick < rg + rr) begin
                    chroma = 1'b0; in_polygon = 1'b0; rr--;
                end else begin
                    chroma = 1'b1; in_polygon = 1'($urandom_range(0, 1)); rb--;
                end
            end
            tick();
        end
        pixel_valid = 1'b0;
        chroma      = 1'b0;
        in_polygon  = 1'b0;
    endtask

    task automatic begin_game_if_needed();
        if (cur_round == 0 || game_done) begin
            start = 1'b1;
            tick();
            start = 1'b0;
            cur_round = 1;
            game_done = 0;
            exp_score = 0;
            check("start_round", int'(round_num), 1);
            check("start_game_over", int'(game_over), 0);
`ifdef ROUND_SCORE_ACCUM_EN
            check("start_score", int'(total_score), 0);
`endif
        end
    endtask

    task automatic show_to_judge();
        vsync();
        check("show_f1_judging", int'(judging), 0);
        check("show_game_in", int'(game_in), 1);
        start = 1'b1;
        tick();
        start = 1'b0;
        check("start_in_show_round", int'(round_num), cur_round);
        vsync();
        check("judge_entry", int'(judging), 1);
        check("judge_game_in", int'(game_in), 0);
    endtask

    task automatic do_round(input int g, input int r, input int b, input int vpx,
                            input logic [2:0] exp);
        begin_game_if_needed();
        show_to_judge();
        send_pixels(g, r, b);
        vsync_pulse = 1'b1;
        if (vpx != 0) begin
            pixel_valid = 1'b1; chroma = 1'b0; in_polygon = 1'b0;
        end
        tick();
        vsync_pulse = 1'b0;
        pixel_valid = 1'b0;
        check("result_valid", int'(result_valid), 1);
        check("verdict", int'({perfect, good, bad}), int'(exp));
        exp_score = (exp_score + pts(exp) > 127) ? 127 : exp_score + pts(exp);
`ifdef ROUND_SCORE_ACCUM_EN
        check("score", int'(total_score), exp_score);
`endif
        $display("round %0d grn=%0d red=%0d bg=%0d vpx=%0d verdict=%b expected=%b",
                 cur_round, g, r, b, vpx, {perfect, good, bad}, exp);
        vsync();
        check("result_exit_valid", int'(result_valid), 0);
        check("result_exit_verdict", int'({perfect, good, bad}), 0);
        if (cur_round == NR) begin
            game_done = 1;
            check("done_game_over", int'(game_over), 1);
            check("done_game_in", int'(game_in), 1);
        end else begin
            cur_round++;
            check("next_round", int'(round_num), cur_round);
            check("next_game_over", int'(game_over), 0);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tbl[0] = '{900, 100, 0,  0, 3'b100};
        tbl[1] = '{600, 400, 0,  0, 3'b010};
        tbl[2] = '{499, 501, 0,  0, 3'b001};
        tbl[3] = '{800, 200, 0,  0, 3'b100};
        tbl[4] = '{0,   0,   60, 0, 3'b001};
        tbl[5] = '{4,   1,   5,  1, 3'b100};
        tbl[6] = '{799, 201, 3,  0, 3'b010};

        // Reset state
        #12;
        check("rst_game_in", int'(game_in), 1);
        check("rst_round", int'(round_num), 0);
        check("rst_outputs", int'({judging, perfect, good, bad, result_valid, game_over}), 0);
        @(negedge clk);
        reset = 1'b0;
        tick();
        // vsync without start does nothing
        vsync();
        vsync();
        vsync();
        check("idle_vsync_judging", int'(judging), 0);
        check("idle_vsync_round", int'(round_num), 0);
        check("idle_vsync_game_in", int'(game_in), 1);

        // Table vectors (spans games; restarts from DONE)
        for (int i = 0; i < 7; i++)
            do_round(tbl[i].grn, tbl[i].red, tbl[i].bg, tbl[i].vsync_px, tbl[i].exp);

        // Reset asserted mid-frame in JUDGE with nonzero counts
        begin_game_if_needed();
        show_to_judge();
        send_pixels(10, 3, 2);
        #2;
        reset = 1'b1;
        #1;
        check("async_rst_judging", int'(judging), 0);
        check("async_rst_game_in", int'(game_in), 1);
        check("async_rst_round", int'(round_num), 0);
        check("async_rst_outputs", int'({perfect, good, bad, result_valid, game_over}), 0);
        @(negedge clk);
        reset = 1'b0;
        cur_round = 0;
        game_done = 0;
        exp_score = 0;
        tick();
        vsync();
        vsync();
        check("post_rst_judging", int'(judging), 0);
        check("post_rst_game_in", int'(game_in), 1);
        check("post_rst_round", int'(round_num), 0);
        $display("reset during judge applied");

        // Randomized rounds against the reference model
        for (int i = 0; i < 15; i++) begin
            int g, r, b, vpx, k, mode;
            mode = $urandom_range(0, 3);
            k = $urandom_range(1, 60);
            if (mode == 0) begin
                g = 4 * k; r = k;
            end else if (mode == 1) begin
                g = k; r = k;
            end else begin
                g = $urandom_range(0, 300); r = $urandom_range(0, 300);
            end
            b   = $urandom_range(0, 10);
            vpx = $urandom_range(0, 1);
            do_round(g, r, b, vpx, ref_verdict(g, r));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
